// File: rtl/io_bus_ctrl_pkg.sv
// Shared definitions for the I/O bus sequencer: state encodings, counter width and defaults.
// The optional turnaround state is only reachable when IO_BUS_TURNAROUND_EN is defined.
package io_bus_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      DONE   = 3'd3,
      TURN   = 3'd4
   } state_t;

   localparam int unsigned CNT_W           = 8;
   localparam int unsigned DEFAULT_WIDTH   = 16;
   localparam int unsigned DEFAULT_NPORTS  = 4;
   localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/io_timeout_cnt.sv
// 8-bit saturating wait counter with clear/enable and a terminal-count flag.
// tc_c is high when the next enabled increment would reach TIMEOUT.
module io_timeout_cnt
   import io_bus_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc_c
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

   // Terminal when this wait cycle is the TIMEOUT-th one since the clear.
   always_comb begin
      tc_c = (count >= CNT_W'(TIMEOUT - 1));
   end

endmodule

// File: rtl/io_bus_ctrl.sv
// Sequencer for the shared bidirectional I/O bus: setup, strobe with wait states, done.
// Define IO_BUS_TURNAROUND_EN to insert a bus-idle TURN cycle after every write.
module io_bus_ctrl
   import io_bus_ctrl_pkg::*;
#(
   parameter  int unsigned WIDTH   = DEFAULT_WIDTH,
   parameter  int unsigned NPORTS  = DEFAULT_NPORTS,
   parameter  int unsigned TIMEOUT = DEFAULT_TIMEOUT,
   localparam int unsigned AW      = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata,
   output logic              stall,
   output logic              done,
   output logic              err,
   output logic              oe,
   output logic [WIDTH-1:0]  bus_out,
   input  logic [WIDTH-1:0]  bus_in,
   output logic [NPORTS-1:0] port_sel,
   output logic              port_rd,
   output logic              port_wr,
   input  logic              port_ready
);

   state_t              state;
   state_t              next_state;
   logic                we_q;
   logic [AW-1:0]       addr_q;
   logic                txn_we;
   logic [AW-1:0]       txn_addr;
   logic [NPORTS-1:0]   sel_d;
   logic                rd_d;
   logic                wr_d;
   logic                oe_d;
   logic                done_d;
   logic                cnt_clr;
   logic                cnt_en;
   logic                tc_c;

   io_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tc_c  (tc_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state, stall, and next values of the registered bus outputs.
   always_comb begin
      next_state = state;
      stall      = 1'b0;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      txn_we     = we_q;
      txn_addr   = addr_q;
      sel_d      = '0;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
      oe_d       = 1'b0;
      done_d     = 1'b0;

      case (state)
         IDLE: begin
            stall    = req;
            txn_we   = we;
            txn_addr = addr;
            if (req) begin
               next_state = SETUP;
            end
         end
         SETUP: begin
            stall      = 1'b1;
            cnt_clr    = 1'b1;
            next_state = STROBE;
         end
         STROBE: begin
            stall = 1'b1;
            if (port_ready) begin
               next_state = DONE;
            end else begin
               cnt_en = 1'b1;
               if (tc_c) begin
                  next_state = DONE;
               end
            end
         end
         DONE: begin
`ifdef IO_BUS_TURNAROUND_EN
            next_state = we_q ? TURN : IDLE;
`else
            next_state = IDLE;
`endif
         end
`ifdef IO_BUS_TURNAROUND_EN
         TURN: begin
            stall      = req;
            next_state = IDLE;
         end
`endif
         default: begin
            next_state = IDLE;
         end
      endcase

      // Outputs are decoded from the state being entered so they register cleanly.
      case (next_state)
         SETUP: begin
            sel_d = NPORTS'(1) << txn_addr;
            oe_d  = txn_we;
         end
         STROBE: begin
            sel_d = NPORTS'(1) << txn_addr;
            rd_d  = ~txn_we;
            wr_d  = txn_we;
            oe_d  = txn_we;
         end
         DONE: begin
            done_d = 1'b1;
            oe_d   = txn_we;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         port_sel <= '0;
         port_rd  <= 1'b0;
         port_wr  <= 1'b0;
         oe       <= 1'b0;
         done     <= 1'b0;
      end else begin
         port_sel <= sel_d;
         port_rd  <= rd_d;
         port_wr  <= wr_d;
         oe       <= oe_d;
         done     <= done_d;
      end
   end

   // Transaction capture, read data and timeout error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         bus_out <= '0;
         rdata   <= '0;
         err     <= 1'b0;
      end else begin
         if ((state == IDLE) && req) begin
            we_q   <= we;
            addr_q <= addr;
            err    <= 1'b0;
            if (we) begin
               bus_out <= wdata;
            end
         end
         if (state == STROBE) begin
            if (port_ready) begin
               if (!we_q) begin
                  rdata <= bus_in;
               end
            end else if (tc_c) begin
               err <= 1'b1;
               if (!we_q) begin
                  rdata <= '1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: reads, writes with waits, timeout, async reset, back-to-back.
module tb_io_bus_ctrl;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned NPORTS  = 4;
   localparam int unsigned TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              reset;
   logic              req;
   logic              we;
   logic [1:0]        addr;
   logic [WIDTH-1:0]  wdata;
   logic [WIDTH-1:0]  rdata;
   logic              stall;
   logic              done;
   logic              err;
   logic              oe;
   logic [WIDTH-1:0]  bus_out;
   logic [WIDTH-1:0]  bus_in;
   logic [NPORTS-1:0] port_sel;
   logic              port_rd;
   logic              port_wr;
   logic              port_ready;

   int checks   = 0;
   int failures = 0;

   int r_stall;
   int r_oe;
   int r_strobe;
   int r_done_at;
   int r_bad;

   always #5 clk = ~clk;

   io_bus_ctrl #(
      .WIDTH   (WIDTH),
      .NPORTS  (NPORTS),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .stall      (stall),
      .done       (done),
      .err        (err),
      .oe         (oe),
      .bus_out    (bus_out),
      .bus_in     (bus_in),
      .port_sel   (port_sel),
      .port_rd    (port_rd),
      .port_wr    (port_wr),
      .port_ready (port_ready)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transaction from IDLE; the peripheral answers after `waits` strobe cycles.
   task automatic run_txn(input logic w, input logic [1:0] a, input logic [15:0] d,
                          input int waits);
      logic [3:0] exp_sel;
      exp_sel    = 4'b0001 << a;
      r_stall    = 0;
      r_oe       = 0;
      r_strobe   = 0;
      r_done_at  = -1;
      r_bad      = 0;
      req        = 1'b1;
      we         = w;
      addr       = a;
      wdata      = d;
      port_ready = (waits == 0);
      #1;
      for (int k = 0; k < 64; k++) begin
         if (k > 0) step();
         if (stall) r_stall++;
         if (oe) r_oe++;
         if ((port_rd && w) || (port_wr && !w)) r_bad++;
         if ((k >= 1) && stall && (port_sel !== exp_sel)) r_bad++;
         if (port_rd || port_wr) begin
            r_strobe++;
            port_ready = (r_strobe > waits);
         end
         if (done) begin
            if ((port_sel != 4'b0000) || port_rd || port_wr || stall) r_bad++;
            r_done_at = k;
            req       = 1'b0;
            break;
         end
      end
      port_ready = 1'b0;
   endtask

   initial begin
      int dcount;
      int first_done;
      int second_done;
      int rd_setup;
      logic oe_gap;

      reset      = 1'b1;
      req        = 1'b0;
      we         = 1'b0;
      addr       = 2'd0;
      wdata      = '0;
      bus_in     = '0;
      port_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rst_rdata", 32'(rdata), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_bus_out", 32'(bus_out), 32'h0);
      check("rst_oe", 32'(oe), 32'h0);
      check("rst_port_sel", 32'(port_sel), 32'h0);
      check("rst_strobes", 32'({port_rd, port_wr}), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_stall", 32'(stall), 32'h0);

      // Zero-wait read from port 2
      step();
      bus_in = 16'hA5C3;
      run_txn(1'b0, 2'd2, 16'h0000, 0);
      check("rd0_done_at", 32'(r_done_at), 32'd3);
      check("rd0_stall", 32'(r_stall), 32'd3);
      check("rd0_strobe", 32'(r_strobe), 32'd1);
      check("rd0_oe", 32'(r_oe), 32'd0);
      check("rd0_sel", 32'(r_bad), 32'd0);
      check("rd0_rdata", 32'(rdata), 32'hA5C3);
      check("rd0_err", 32'(err), 32'h0);
      step();
      check("rd0_done_pulse", 32'(done), 32'h0);

      // Write to port 1 with two wait states
      repeat (2) step();
      run_txn(1'b1, 2'd1, 16'h1234, 2);
      check("wr2_done_at", 32'(r_done_at), 32'd5);
      check("wr2_stall", 32'(r_stall), 32'd5);
      check("wr2_strobe", 32'(r_strobe), 32'd3);
      check("wr2_oe", 32'(r_oe), 32'd5);
      check("wr2_sel", 32'(r_bad), 32'd0);
      check("wr2_bus_out", 32'(bus_out), 32'h1234);
      check("wr2_rdata_kept", 32'(rdata), 32'hA5C3);
      step();
      check("wr2_oe_release", 32'(oe), 32'h0);

      // Read from port 3 that never gets an acknowledge
      repeat (2) step();
      bus_in = 16'h1111;
      run_txn(1'b0, 2'd3, 16'h0000, 255);
      check("to_done_at", 32'(r_done_at), 32'd17);
      check("to_strobe", 32'(r_strobe), 32'd15);
      check("to_sel", 32'(r_bad), 32'd0);
      check("to_err", 32'(err), 32'h1);
      check("to_rdata", 32'(rdata), 32'hFFFF);
      repeat (2) step();
      check("to_err_hold", 32'(err), 32'h1);

      // Normal read to port 0 clears the error
      bus_in = 16'h0F0F;
      run_txn(1'b0, 2'd0, 16'h0000, 0);
      check("clr_done_at", 32'(r_done_at), 32'd3);
      check("clr_err", 32'(err), 32'h0);
      check("clr_rdata", 32'(rdata), 32'h0F0F);

      // Asynchronous reset in the middle of a write strobe
      repeat (2) step();
      req        = 1'b1;
      we         = 1'b1;
      addr       = 2'd3;
      wdata      = 16'hBEEF;
      port_ready = 1'b0;
      step();
      step();
      check("rst_mid_wr_active", 32'({oe, port_wr, port_sel}), 32'({1'b1, 1'b1, 4'b1000}));
      #2;
      reset = 1'b1;
      req   = 1'b0;
      #1;
      check("rst_mid_oe", 32'(oe), 32'h0);
      check("rst_mid_wr", 32'(port_wr), 32'h0);
      check("rst_mid_sel", 32'(port_sel), 32'h0);
      check("rst_mid_idle", 32'(stall), 32'h0);
      check("rst_mid_bus_out", 32'(bus_out), 32'h0);
      step();
      reset  = 1'b0;
      dcount = 0;
      for (int k = 0; k < 4; k++) begin
         if (done) dcount++;
         step();
      end
      check("rst_mid_no_done", 32'(dcount), 32'd0);
      run_txn(1'b1, 2'd3, 16'hBEEF, 0);
      check("rst_after_done_at", 32'(r_done_at), 32'd3);
      check("rst_after_bus_out", 32'(bus_out), 32'hBEEF);
      check("rst_after_sel", 32'(r_bad), 32'd0);

      // Back-to-back OUT then IN with req held through DONE
      repeat (2) step();
      bus_in      = 16'hC3C3;
      req         = 1'b1;
      we          = 1'b1;
      addr        = 2'd1;
      wdata       = 16'h5A5A;
      port_ready  = 1'b1;
      dcount      = 0;
      first_done  = -1;
      second_done = -1;
      rd_setup    = -1;
      oe_gap      = 1'b1;
      #1;
      for (int k = 0; k < 30; k++) begin
         if (k > 0) step();
         if ((port_sel == 4'b0100) && (rd_setup < 0)) rd_setup = k;
         if (k == 4) oe_gap = oe;
         if (done) begin
            dcount++;
            if (dcount == 1) begin
               first_done = k;
               we         = 1'b0;
               addr       = 2'd2;
            end else begin
               second_done = k;
               req         = 1'b0;
               break;
            end
         end
      end
      port_ready = 1'b0;
      check("b2b_first_done", 32'(first_done), 32'd3);
      check("b2b_gap_oe", 32'(oe_gap), 32'h0);
`ifdef IO_BUS_TURNAROUND_EN
      check("b2b_rd_setup", 32'(rd_setup), 32'd6);
      check("b2b_second_done", 32'(second_done), 32'd8);
`else
      check("b2b_rd_setup", 32'(rd_setup), 32'd5);
      check("b2b_second_done", 32'(second_done), 32'd7);
`endif
      check("b2b_rdata", 32'(rdata), 32'hC3C3);
      check("b2b_bus_out", 32'(bus_out), 32'h5A5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
